// File: rtl/nco_phase_bank_pkg.sv
//------------------------------------------------------------------------------
// nco_phase_bank_pkg : shared config-select encodings and width helper
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package nco_phase_bank_pkg;

  localparam logic [1:0] CFG_STEP      = 2'd0;
  localparam logic [1:0] CFG_OFFSET    = 2'd1;
  localparam logic [1:0] CFG_SWEEP_INC = 2'd2;
  localparam logic [1:0] CFG_SWEEP_LIM = 2'd3;

  // Channel-select width leaves room for at least one out-of-range code,
  // so a bad channel address is always representable and detectable.
  function automatic int ch_w(input int nch);
    return (nch < 1) ? 1 : $clog2(nch + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nco_acc_lane.sv
//------------------------------------------------------------------------------
// nco_acc_lane : one NCO channel - shadow/active config, accumulator, wrap
// Optional linear sweep when NCO_SWEEP_EN is defined.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nco_acc_lane
  import nco_phase_bank_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_sel_i,
  input  logic [ACC_W-1:0] wr_data_i,
  input  logic             commit_i,
  output logic [OUT_W-1:0] phase_o,
  output logic             wrap_o
);

  logic [ACC_W-1:0] step_sh_q, step_sh_d, step_act_q;
  logic [ACC_W-1:0] off_sh_q, off_sh_d, off_act_q;
  logic [ACC_W-1:0] acc_q;
  logic [OUT_W-1:0] phase_q;
  logic             wrap_q;
  logic [ACC_W-1:0] step_eff;
  logic [ACC_W:0]   acc_sum;

  // Shadow next-state includes a same-cycle write so a commit can bypass it.
  always_comb begin
    step_sh_d = step_sh_q;
    off_sh_d  = off_sh_q;
    if (wr_en_i && (wr_sel_i == CFG_STEP))   step_sh_d = wr_data_i;
    if (wr_en_i && (wr_sel_i == CFG_OFFSET)) off_sh_d  = wr_data_i;
  end

`ifdef NCO_SWEEP_EN
  logic [ACC_W-1:0] inc_sh_q, inc_sh_d, inc_act_q;
  logic [ACC_W-1:0] lim_sh_q, lim_sh_d, lim_act_q;
  logic [ACC_W-1:0] sweep_q, sweep_d;
  logic [ACC_W:0]   sweep_sum;

  always_comb begin
    inc_sh_d  = inc_sh_q;
    lim_sh_d  = lim_sh_q;
    if (wr_en_i && (wr_sel_i == CFG_SWEEP_INC)) inc_sh_d = wr_data_i;
    if (wr_en_i && (wr_sel_i == CFG_SWEEP_LIM)) lim_sh_d = wr_data_i;
    sweep_sum = {1'b0, sweep_q} + {1'b0, inc_act_q};
    sweep_d   = sweep_q;
    if (sync_i || commit_i) begin
      sweep_d = '0;
    end else if (en_i) begin
      if (inc_act_q == '0)                    sweep_d = '0;
      else if (sweep_sum > {1'b0, lim_act_q}) sweep_d = '0;
      else                                    sweep_d = sweep_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc_sh_q  <= '0;
      inc_act_q <= '0;
      lim_sh_q  <= '0;
      lim_act_q <= '0;
      sweep_q   <= '0;
    end else begin
      inc_sh_q <= inc_sh_d;
      lim_sh_q <= lim_sh_d;
      if (commit_i) begin
        inc_act_q <= inc_sh_d;
        lim_act_q <= lim_sh_d;
      end
      sweep_q <= sweep_d;
    end
  end

  assign step_eff = step_act_q + sweep_q;
`else
  assign step_eff = step_act_q;
`endif

  assign acc_sum = {1'b0, acc_q} + {1'b0, step_eff};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_sh_q  <= '0;
      step_act_q <= '0;
      off_sh_q   <= '0;
      off_act_q  <= '0;
      acc_q      <= '0;
      phase_q    <= '0;
      wrap_q     <= 1'b0;
    end else begin
      step_sh_q <= step_sh_d;
      off_sh_q  <= off_sh_d;
      if (commit_i) begin
        step_act_q <= step_sh_d;
        off_act_q  <= off_sh_d;
      end
      if (sync_i) begin
        acc_q  <= '0;
        wrap_q <= 1'b0;
      end else if (en_i) begin
        acc_q   <= acc_sum[ACC_W-1:0];
        wrap_q  <= acc_sum[ACC_W];
        phase_q <= OUT_W'((acc_q + off_act_q) >> (ACC_W - OUT_W));
      end else begin
        wrap_q <= 1'b0;
      end
    end
  end

  assign phase_o = phase_q;
  assign wrap_o  = wrap_q;

endmodule

`default_nettype wire

// File: rtl/nco_phase_bank.sv
//------------------------------------------------------------------------------
// nco_phase_bank : multi-channel NCO phase accumulator bank with config port
// Optional sweep feature: NCO_SWEEP_EN.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nco_phase_bank
  import nco_phase_bank_pkg::*;
#(
  parameter  int NCH   = 2,
  parameter  int ACC_W = 32,
  parameter  int OUT_W = 8,
  localparam int CH_W  = ch_w(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sync,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_sel,
  input  logic [ACC_W-1:0]   cfg_data,
  input  logic               cfg_commit,
  output logic               cfg_err,
  output logic [NCH*OUT_W-1:0] phase_out,
  output logic               phase_valid,
  output logic [NCH-1:0]     wrap
);

  logic cfg_ready_q, cfg_err_q, phase_valid_q;
  logic wr_acc, ch_ok;

  assign wr_acc = cfg_valid & cfg_ready_q;
  assign ch_ok  = (cfg_ch < CH_W'(NCH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready_q   <= 1'b0;
      cfg_err_q     <= 1'b0;
      phase_valid_q <= 1'b0;
    end else begin
      cfg_ready_q   <= 1'b1;
      if (wr_acc && !ch_ok) cfg_err_q <= 1'b1;
      phase_valid_q <= en & ~sync;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    nco_acc_lane #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en),
      .sync_i    (sync),
      .wr_en_i   (wr_acc && ch_ok && (cfg_ch == CH_W'(i))),
      .wr_sel_i  (cfg_sel),
      .wr_data_i (cfg_data),
      .commit_i  (cfg_commit),
      .phase_o   (phase_out[i*OUT_W +: OUT_W]),
      .wrap_o    (wrap[i])
    );
  end

  assign cfg_ready   = cfg_ready_q;
  assign cfg_err     = cfg_err_q;
  assign phase_valid = phase_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_nco_phase_bank.sv
//------------------------------------------------------------------------------
// tb_nco_phase_bank : scoreboard bench for nco_phase_bank (NCH=2, 32/8 bits)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_nco_phase_bank;

  localparam int NCH   = 2;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;
`ifdef NCO_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, sync = 1'b0;
  logic        cfg_valid = 1'b0, cfg_commit = 1'b0;
  logic [1:0]  cfg_ch = '0, cfg_sel = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_ready, cfg_err, phase_valid;
  logic [15:0] phase_out;
  logic [1:0]  wrap;

  always #5 clk = ~clk;

  nco_phase_bank #(.NCH(NCH), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_err(cfg_err), .phase_out(phase_out), .phase_valid(phase_valid),
    .wrap(wrap)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel arrays indexed [channel][field]
  typedef struct packed { logic [15:0] ph; logic [1:0] wr; } exp_t;
  exp_t        q[$];
  logic [31:0] m_acc [NCH];
  logic [31:0] m_cur [NCH];
  logic [31:0] m_sh  [NCH][4];
  logic [31:0] m_act [NCH][4];
  bit          m_ready, m_err;
  logic [15:0] last_ph = '0;
  bit          mon_en = 1'b0;

  task automatic model_edge();
    logic [32:0] s;
    logic [31:0] eff [NCH];
    logic [31:0] t;
    exp_t        e;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = '0; m_cur[c] = '0;
        for (int k = 0; k < 4; k++) begin m_sh[c][k] = '0; m_act[c][k] = '0; end
      end
      m_ready = 1'b0; m_err = 1'b0; q.delete(); last_ph = '0;
      return;
    end
    for (int c = 0; c < NCH; c++) eff[c] = m_act[c][0] + m_cur[c];
    if (sync) begin
      for (int c = 0; c < NCH; c++) begin m_acc[c] = '0; m_cur[c] = '0; end
    end else if (en) begin
      for (int c = 0; c < NCH; c++) begin
        t = m_acc[c] + m_act[c][1];
        e.ph[c*8 +: 8] = t[31:24];
        s = {1'b0, m_acc[c]} + {1'b0, eff[c]};
        e.wr[c]  = s[32];
        m_acc[c] = s[31:0];
        if (SWEEP) begin
          if (m_act[c][2] == 0) m_cur[c] = '0;
          else begin
            s = {1'b0, m_cur[c]} + {1'b0, m_act[c][2]};
            m_cur[c] = (s > {1'b0, m_act[c][3]}) ? 32'd0 : s[31:0];
          end
        end
      end
      q.push_back(e);
    end
    if (cfg_valid && m_ready) begin
      if (cfg_ch >= NCH) m_err = 1'b1;
      else if (SWEEP || cfg_sel < 2) m_sh[cfg_ch][cfg_sel] = cfg_data;
    end
    if (cfg_commit) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < 4; k++) m_act[c][k] = m_sh[c][k];
        m_cur[c] = '0;
      end
    end
    m_ready = 1'b1;
  endtask

  task automatic cyc(input bit e, input bit s, input bit v, input logic [1:0] ch,
                     input logic [1:0] sel, input logic [31:0] d, input bit cm);
    en = e; sync = s; cfg_valid = v; cfg_ch = ch; cfg_sel = sel; cfg_data = d; cfg_commit = cm;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] d);
    cyc(0, 0, 1, ch, sel, d, 0);
  endtask

  // Monitor: pops expected phases whenever the DUT flags a valid output
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      if (phase_valid === 1'b1) begin
        if (q.size() == 0) chk("spurious_valid", phase_valid, 1'b0);
        else begin
          e = q.pop_front();
          chk("phase", phase_out, e.ph);
          chk("wrap", wrap, e.wr);
          last_ph = e.ph;
        end
      end else begin
        chk("missing_valid", q.size(), 0);
        chk("phase_hold", phase_out, last_ph);
        chk("wrap_idle", wrap, 2'b00);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcnt;
    logic [7:0] d8;
    rst_n = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_phase", phase_out, 16'h0);
    chk("rst_valid", phase_valid, 1'b0);
    chk("rst_wrap", wrap, 2'b00);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    rst_n = 1'b1;
    #2;
    chk("ready_first_cycle", cfg_ready, 1'b0);
    idle(1);
    chk("ready_after", cfg_ready, 1'b1);
    mon_en = 1'b1;

    // Step 1/256 turn on both channels, ch1 leads by a quarter turn
    wr(0, 0, 32'h0100_0000);
    wr(1, 0, 32'h0100_0000);
    wr(1, 1, 32'h4000_0000);
    cyc(0, 0, 0, 0, 0, 0, 1);
    wcnt = 0;
    for (int i = 0; i < 300; i++) begin
      run(1);
      if (wrap[0]) wcnt++;
    end
    chk("wrap0_count", wcnt, 1);
    d8 = phase_out[15:8] - phase_out[7:0];
    chk("ch1_lead", d8, 8'h40);

    // Shadow write without commit, then commit, then bypassed write+commit
    cyc(1, 0, 1, 0, 0, 32'h0200_0000, 0);
    run(8);
    cyc(1, 0, 0, 0, 0, 0, 1);
    run(8);
    cyc(1, 0, 1, 0, 0, 32'h0300_0000, 1);
    run(8);

    // Hold, then sync restarts at the offsets
    idle(5);
    cyc(1, 1, 0, 0, 0, 0, 0);
    run(1);
    chk("sync_restart", phase_out, 16'h4000);
    run(4);

    // Out-of-range channel write
    wr(3, 0, 32'hDEAD_BEEF);
    chk("cfg_err", cfg_err, 1'b1);
    chk("cfg_err_model", cfg_err, m_err);
    cyc(0, 0, 0, 0, 0, 0, 1);
    run(6);

    // Sweep: step 0, inc 1/256 turn, limit 3/256
    wr(0, 0, 32'h0);
    wr(0, 2, 32'h0100_0000);
    wr(0, 3, 32'h0300_0000);
    cyc(0, 0, 0, 0, 0, 0, 1);
    run(12);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 32) == 0, ($urandom % 3) == 0,
          2'($urandom % 4), 2'($urandom % 4), $urandom, ($urandom % 16) == 0);
    end
    chk("cfg_err_rand", cfg_err, m_err);

    // Reset mid-operation with a pending write and commit
    rst_n = 1'b0;
    cyc(1, 0, 1, 0, 0, 32'h1234_5678, 1);
    chk("mid_rst_phase", phase_out, 16'h0);
    chk("mid_rst_err", cfg_err, 1'b0);
    chk("mid_rst_ready", cfg_ready, 1'b0);
    rst_n = 1'b1;
    idle(1);
    chk("mid_rst_ready_after", cfg_ready, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    run(4);
    idle(3);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
